reg_scoreboard: RTL and testbench

//  Producer-side partner to the ID/EX forwarding selector: tracks which registers have writes in flight

---
 rtl/reg_scoreboard.sv | 127 ++++++++++++
 tb/tb_reg_scoreboard.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register write scoreboard beside ID: counts in-flight writes per architectural register
// and stalls ID when a source or destination cannot yet be handled.
module reg_scoreboard #(
    parameter int CNT_W = 2,
    parameter int TOT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_id,
    input  logic             issue_en,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    output logic             stall_id,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic [TOT_W-1:0] in_flight,
    output logic             err
);
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_CSR       = 7'b1110011;

    localparam int              SUM_W   = CNT_W + 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [SUM_W-1:0] TOT_MAX = SUM_W'((1 << TOT_W) - 1);

    logic [6:0] opc;
    logic [4:0] rd, rs1, rs2;
    logic       known, writes_rd, uses_rs1, uses_rs2;
    logic       unused_bits;

    assign opc = inst_id[6:0];
    assign rd  = inst_id[11:7];
    assign rs1 = inst_id[19:15];
    assign rs2 = inst_id[24:20];
    assign unused_bits = ^{inst_id[31:25], inst_id[13:12]};

    always_comb begin
        known    = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opc)
            OPC_LOAD, OPC_JALR, OPC_ARI_ITYPE: begin known = 1'b1; uses_rs1 = 1'b1; end
            OPC_STORE, OPC_BRANCH, OPC_ARI_RTYPE: begin
                known = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_JAL, OPC_LUI, OPC_AUIPC: known = 1'b1;
            OPC_CSR: begin known = 1'b1; uses_rs1 = ~inst_id[14]; end
            default: known = 1'b0;
        endcase
    end
    assign writes_rd = known && (opc != OPC_STORE) && (opc != OPC_BRANCH);

    // Packed view with entry 0 fixed at zero so x0 never reads as pending.
    logic [CNT_W-1:0]            pend_reg [1:31];
    logic [31:0][CNT_W-1:0]      pend_view;
    logic [CNT_W-1:0]            rs1_pend, rs2_pend, rd_pend, wb_pend;
    logic                        rd_full, issue, inc_eff, dec_eff;
    logic [SUM_W-1:0]            total_reg, total_next;
    logic [TOT_W-1:0]            in_flight_reg;
    logic                        err_reg;

    assign pend_view[0] = '0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_pend
            logic inc, dec;
            assign inc = issue && (rd == 5'(gi));
            assign dec = wb_valid && (wb_rd == 5'(gi));
            assign pend_view[gi] = pend_reg[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    pend_reg[gi] <= '0;
                else if (inc && !dec)
                    pend_reg[gi] <= pend_reg[gi] + CNT_ONE;
                else if (dec && !inc && pend_reg[gi] != '0)
                    pend_reg[gi] <= pend_reg[gi] - CNT_ONE;
            end
        end
    endgenerate

    assign rs1_pend = pend_view[rs1];
    assign rs2_pend = pend_view[rs2];
    assign rd_pend  = pend_view[rd];
    assign wb_pend  = pend_view[wb_rd];

    // A lone pending write retiring this cycle is supplied by the WB forward path.
    assign rs1_busy = uses_rs1 && (rs1 != 5'd0) && (rs1_pend != '0) &&
                      !(wb_valid && wb_rd == rs1 && rs1_pend == CNT_ONE);
    assign rs2_busy = uses_rs2 && (rs2 != 5'd0) && (rs2_pend != '0) &&
                      !(wb_valid && wb_rd == rs2 && rs2_pend == CNT_ONE);
    assign rd_full  = writes_rd && (rd != 5'd0) && (rd_pend == CNT_MAX) &&
                      !(wb_valid && wb_rd == rd);
    assign stall_id = (rs1_busy | rs2_busy | rd_full) & ~flush;
    assign issue    = issue_en & ~stall_id & ~flush & writes_rd & (rd != 5'd0);

    // Net effect on the total mirrors the per-register cancel/underflow rules.
    assign inc_eff = issue && !(wb_valid && wb_rd == rd);
    assign dec_eff = wb_valid && (wb_rd != 5'd0) && (wb_pend != '0) && !(issue && rd == wb_rd);
    assign total_next = total_reg + SUM_W'(inc_eff) - SUM_W'(dec_eff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_reg     <= '0;
            in_flight_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            total_reg     <= total_next;
            in_flight_reg <= (total_next > TOT_MAX) ? TOT_MAX[TOT_W-1:0] : total_next[TOT_W-1:0];
            if (wb_valid && wb_rd != 5'd0 && wb_pend == '0 && !(issue && rd == wb_rd))
                err_reg <= 1'b1;
        end
    end

    assign in_flight = in_flight_reg;
    assign err       = err_reg;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized bench for reg_scoreboard: an array-of-counts model predicts every output each cycle,
// plus directed scenarios with literal expectations.
module tb_reg_scoreboard;
    localparam logic [6:0] O_LOAD  = 7'b0000011, O_STORE = 7'b0100011, O_BRANCH = 7'b1100011;
    localparam logic [6:0] O_JALR  = 7'b1100111, O_JAL   = 7'b1101111, O_ITYPE  = 7'b0010011;
    localparam logic [6:0] O_RTYPE = 7'b0110011, O_LUI   = 7'b0110111, O_AUIPC  = 7'b0010111;
    localparam logic [6:0] O_CSR   = 7'b1110011;
    localparam int PMAX = 3;
    localparam int IMAX = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_id = '0;
    logic        issue_en = 1'b0, flush = 1'b0, wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        stall_id, rs1_busy, rs2_busy, err;
    logic [3:0]  in_flight;

    int tests = 0;
    int fails = 0;
    int m_pend [32];
    bit m_err;

    reg_scoreboard #(.CNT_W(2), .TOT_W(4)) dut (
        .clk(clk), .rst(rst), .inst_id(inst_id), .issue_en(issue_en), .flush(flush),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_id(stall_id), .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy), .in_flight(in_flight), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_known(logic [31:0] i);
        logic [6:0] o = i[6:0];
        return o inside {O_LOAD, O_STORE, O_BRANCH, O_JALR, O_JAL, O_ITYPE, O_RTYPE, O_LUI, O_AUIPC, O_CSR};
    endfunction
    function automatic bit m_writes(logic [31:0] i);
        return m_known(i) && !(i[6:0] inside {O_STORE, O_BRANCH});
    endfunction
    function automatic bit m_uses1(logic [31:0] i);
        return (i[6:0] inside {O_JALR, O_BRANCH, O_LOAD, O_STORE, O_ITYPE, O_RTYPE}) ||
               (i[6:0] == O_CSR && i[14] == 1'b0);
    endfunction
    function automatic bit m_uses2(logic [31:0] i);
        return i[6:0] inside {O_BRANCH, O_STORE, O_RTYPE};
    endfunction
    function automatic bit m_src_busy(bit uses, int r);
        if (!uses || r == 0 || m_pend[r] == 0) return 1'b0;
        return !(wb_valid && int'(wb_rd) == r && m_pend[r] == 1);
    endfunction
    function automatic bit m_b1();
        return m_src_busy(m_uses1(inst_id), int'(inst_id[19:15]));
    endfunction
    function automatic bit m_b2();
        return m_src_busy(m_uses2(inst_id), int'(inst_id[24:20]));
    endfunction
    function automatic bit m_stall();
        int rd = int'(inst_id[11:7]);
        bit full = m_writes(inst_id) && rd != 0 && m_pend[rd] == PMAX && !(wb_valid && int'(wb_rd) == rd);
        return (m_b1() || m_b2() || full) && !flush;
    endfunction
    function automatic int m_inflight();
        int s = 0;
        for (int k = 1; k < 32; k++) s += m_pend[k];
        return (s > IMAX) ? IMAX : s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 32; k++) m_pend[k] <= 0;
            m_err <= 1'b0;
        end else begin
            int  rd, wr;
            bit  iss, ret;
            rd  = int'(inst_id[11:7]);
            wr  = int'(wb_rd);
            iss = issue_en && !m_stall() && !flush && m_writes(inst_id) && rd != 0;
            ret = wb_valid && wr != 0;
            if (!(iss && ret && rd == wr)) begin
                if (iss) m_pend[rd] <= m_pend[rd] + 1;
                if (ret) begin
                    if (m_pend[wr] > 0) m_pend[wr] <= m_pend[wr] - 1;
                    else m_err <= 1'b1;
                end
            end
        end
    end

    // Single compare point, mid-cycle, every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            check("stall_id", int'(stall_id), int'(m_stall()));
            check("rs1_busy", int'(rs1_busy), int'(m_b1()));
            check("rs2_busy", int'(rs2_busy), int'(m_b2()));
            check("in_flight", int'(in_flight), m_inflight());
            check("err", int'(err), int'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] enc_i(logic [6:0] opc, int rd, int rs1);
        return {12'd1, 5'(rs1), 3'b000, 5'(rd), opc};
    endfunction
    function automatic logic [31:0] enc_r(int rd, int rs1, int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), O_RTYPE};
    endfunction
    function automatic logic [31:0] enc_s(int rs2, int rs1);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, O_STORE};
    endfunction

    task automatic step(input logic [31:0] i, input bit ie, input bit fl, input bit wv, input int wr);
        @(posedge clk); #1;
        inst_id = i; issue_en = ie; flush = fl; wb_valid = wv; wb_rd = 5'(wr);
        @(negedge clk); #1;
        $display("[TB] inst=%08h ie=%0b fl=%0b wb=%0b/x%0d -> stall=%0b rs1b=%0b rs2b=%0b inf=%0d err=%0b",
                 i, ie, fl, wv, wr, stall_id, rs1_busy, rs2_busy, in_flight, err);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; inst_id = '0; issue_en = 0; flush = 0; wb_valid = 0; wb_rd = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_in_flight", int'(in_flight), 0);
        check("reset_err", int'(err), 0);
        check("reset_stall", int'(stall_id), 0);
    endtask

    logic [6:0] opc_tab [12];

    initial begin
        opc_tab = '{O_LOAD, O_STORE, O_BRANCH, O_JALR, O_JAL, O_ITYPE, O_RTYPE,
                    O_LUI, O_AUIPC, O_CSR, 7'd0, 7'b1111111};

        // 1/2: load-use stall, then cleared by a same-cycle single retirement
        do_reset();
        step(enc_i(O_LOAD, 5, 0), 1, 0, 0, 0);
        step(enc_r(6, 5, 1), 1, 0, 0, 0);
        check("t1_stall", int'(stall_id), 1);
        check("t1_rs1_busy", int'(rs1_busy), 1);
        check("t1_in_flight", int'(in_flight), 1);
        check("t1_model_pend5", m_pend[5], 1);
        step(enc_r(6, 5, 1), 1, 0, 1, 5);
        check("t2_stall_wb", int'(stall_id), 0);
        step(enc_r(7, 5, 0), 0, 0, 0, 0);
        check("t2_rs1_clear", int'(rs1_busy), 0);
        check("t2_in_flight", int'(in_flight), 1);
        check("t2_model_pend5", m_pend[5], 0);

        // 3: x0 destination is never tracked; store reads a clean register
        do_reset();
        step(enc_i(O_ITYPE, 0, 0), 1, 0, 0, 0);
        step(enc_s(5, 0), 1, 0, 0, 0);
        check("t3_stall", int'(stall_id), 0);
        check("t3_in_flight", int'(in_flight), 0);

        // 4: per-register counter full, relieved by a same-cycle retirement
        do_reset();
        for (int k = 0; k < 3; k++) step(enc_i(O_ITYPE, 7, 0), 1, 0, 0, 0);
        step(enc_i(O_ITYPE, 7, 0), 1, 0, 0, 0);
        check("t4_full_stall", int'(stall_id), 1);
        check("t4_in_flight", int'(in_flight), 3);
        step(enc_i(O_ITYPE, 7, 0), 1, 0, 1, 7);
        check("t4_wb_no_stall", int'(stall_id), 0);
        step(32'd0, 0, 0, 0, 0);
        check("t4_in_flight_held", int'(in_flight), 3);
        check("t4_model_pend7", m_pend[7], 3);

        // 5: flush suppresses stall and issue
        do_reset();
        step(enc_i(O_LOAD, 5, 0), 1, 0, 0, 0);
        step(enc_r(6, 5, 1), 1, 1, 0, 0);
        check("t5_flush_stall", int'(stall_id), 0);
        step(32'd0, 0, 0, 0, 0);
        check("t5_in_flight", int'(in_flight), 1);
        check("t5_model_pend6", m_pend[6], 0);

        // 6: retirement of an idle register sets sticky err; async reset clears all
        step(32'd0, 0, 0, 1, 9);
        step(32'd0, 0, 0, 0, 0);
        check("t6_err", int'(err), 1);
        check("t6_in_flight", int'(in_flight), 1);
        step(32'd0, 0, 0, 0, 0);
        check("t6_err_sticky", int'(err), 1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_in_flight", int'(in_flight), 0);
        check("t6_async_err", int'(err), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            int r;
            @(posedge clk); #1;
            rst = ($urandom_range(299) == 0);
            inst_id = {7'($urandom), 5'($urandom_range(7)), 5'($urandom_range(7)),
                       3'($urandom), 5'($urandom_range(7)), opc_tab[$urandom_range(11)]};
            issue_en = ($urandom_range(9) < 8);
            flush    = ($urandom_range(9) == 0);
            r = $urandom_range(7);
            wb_rd    = 5'(r);
            wb_valid = (m_pend[r] > 0 && $urandom_range(1) == 1) || ($urandom_range(59) == 0);
            if (n % 100 == 0)
                $display("[TB] random cycle %0d inst=%08h inf=%0d err=%0b", n, inst_id, in_flight, err);
        end
        @(posedge clk); #1;
        rst = 1'b0; issue_en = 0; wb_valid = 0; flush = 0;
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
